// File: rtl/byte2_pkt_pkg.sv
// Shared widths, FSM state encoding and lane-mask helper for the 2-byte packet packer.
package byte2_pkt_pkg;

  localparam int PKT_W  = 16;
  localparam int LANES  = 4;
  localparam int WORD_W = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    FULL = 2'd2
  } state_e;

  function automatic logic [LANES-1:0] keep_of(input logic [2:0] n);
    keep_of = 4'((5'd1 << n) - 5'd1);
  endfunction

endpackage

// File: rtl/byte2_pkt_out_reg.sv
// Output holding register: loads a packed word, holds it until out_ready is seen.
module byte2_pkt_out_reg
  import byte2_pkt_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic [WORD_W-1:0] data_i,
  input  logic [LANES-1:0]  keep_i,
  input  logic              out_ready_i,
  output logic              out_valid_o,
  output logic [WORD_W-1:0] out_data_o,
  output logic [LANES-1:0]  out_keep_o,
  output logic              free_o
);

  logic              valid_q;
  logic [WORD_W-1:0] data_q;
  logic [LANES-1:0]  keep_q;

  assign free_o      = !valid_q || out_ready_i;
  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;
  assign out_keep_o  = keep_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      keep_q  <= '0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= data_i;
      keep_q  <= keep_i;
    end else if (out_ready_i) begin
      valid_q <= 1'b0;
    end
  end

endmodule

// File: rtl/byte2_pkt_packer.sv
// Packs 16-bit packets into 4-lane words with flush/timeout; optional drop
// counter under BYTE2_PKT_PACKER_STATS_EN.
module byte2_pkt_packer
  import byte2_pkt_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PKT_W-1:0]  byte2_pkt,
  input  logic              pkt_valid,
  input  logic              flush,
  output logic [WORD_W-1:0] out_data,
  output logic [LANES-1:0]  out_keep,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [15:0]       drop_cnt
);

  state_e state_q, state_d;
  logic [2:0] cnt_q, cnt_d, cnt_inc;
  logic [7:0] idle_q, idle_d;
  logic       pend_q, pend_d;
  logic [LANES-1:0][PKT_W-1:0] lane_q, lane_d, lane_w, ld_lanes;
  logic              load, free, tmo;
  logic [LANES-1:0]  ld_keep;
  logic [WORD_W-1:0] ld_data;

  assign cnt_inc = cnt_q + {2'b00, pkt_valid};
  assign tmo     = !pkt_valid && (idle_q == 8'(TIMEOUT - 1));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idle_d   = idle_q;
    pend_d   = pend_q;
    lane_d   = lane_q;
    lane_w   = lane_q;
    ld_lanes = lane_q;
    ld_keep  = '0;
    load     = 1'b0;
    if (pkt_valid) lane_w[cnt_q[1:0]] = byte2_pkt;
    unique case (state_q)
      IDLE: begin
        if (pkt_valid) begin
          lane_d[0] = byte2_pkt;
          cnt_d     = 3'd1;
          idle_d    = '0;
          pend_d    = 1'b0;
          state_d   = FILL;
        end
      end
      FILL: begin
        if (cnt_inc == 3'd4) begin
          lane_d  = lane_w;
          cnt_d   = 3'd4;
          idle_d  = '0;
          state_d = FULL;
        end else if ((flush || pend_q || tmo) && free) begin
          load     = 1'b1;
          ld_lanes = lane_w;
          ld_keep  = keep_of(cnt_inc);
          cnt_d    = '0;
          idle_d   = '0;
          pend_d   = 1'b0;
          state_d  = IDLE;
        end else begin
          lane_d = lane_w;
          cnt_d  = cnt_inc;
          pend_d = pend_q || flush;
          // counter parks at TIMEOUT-1 so a blocked timeout keeps requesting
          if (pkt_valid)  idle_d = '0;
          else if (!tmo)  idle_d = idle_q + 8'd1;
        end
      end
      FULL: begin
        if (free) begin
          load     = 1'b1;
          ld_lanes = lane_q;
          ld_keep  = '1;
          idle_d   = '0;
          pend_d   = 1'b0;
          if (pkt_valid) begin
            lane_d[0] = byte2_pkt;
            cnt_d     = 3'd1;
            state_d   = FILL;
          end else begin
            cnt_d   = '0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ld_data = '0;
    for (int i = 0; i < LANES; i++)
      if (ld_keep[i]) ld_data[i*PKT_W +: PKT_W] = ld_lanes[i];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idle_q  <= '0;
      pend_q  <= 1'b0;
      lane_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idle_q  <= idle_d;
      pend_q  <= pend_d;
      lane_q  <= lane_d;
    end
  end

  byte2_pkt_out_reg u_out (
    .clk        (clk),
    .rst        (rst),
    .load_i     (load),
    .data_i     (ld_data),
    .keep_i     (ld_keep),
    .out_ready_i(out_ready),
    .out_valid_o(out_valid),
    .out_data_o (out_data),
    .out_keep_o (out_keep),
    .free_o     (free)
  );

`ifdef BYTE2_PKT_PACKER_STATS_EN
  logic        drop;
  logic [15:0] drop_q;

  assign drop     = (state_q == FULL) && !free && pkt_valid;
  assign drop_cnt = drop_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                           drop_q <= '0;
    else if (drop && drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
  end
`else
  assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_byte2_pkt_packer.sv
// Randomized bench for byte2_pkt_packer: queue-based reference model plus directed literal checks.
module tb_byte2_pkt_packer;
  import byte2_pkt_pkg::*;

  localparam int TO = 16;
`ifdef BYTE2_PKT_PACKER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] byte2_pkt = '0;
  logic        pkt_valid = 1'b0;
  logic        flush = 1'b0;
  logic        out_ready = 1'b1;
  logic [63:0] out_data;
  logic [3:0]  out_keep;
  logic        out_valid;
  logic [15:0] drop_cnt;

  int total = 0;
  int bad = 0;

  byte2_pkt_packer #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .byte2_pkt(byte2_pkt), .pkt_valid(pkt_valid),
    .flush(flush), .out_data(out_data), .out_keep(out_keep),
    .out_valid(out_valid), .out_ready(out_ready), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%h want=%h", name, $time, act, exp);
    end
  endtask

  // reference model: accumulator as a queue, output slot, flush memory
  logic [15:0] accq[$];
  int          m_idle;
  bit          m_pend;
  bit          m_v;
  logic [63:0] m_d;
  logic [3:0]  m_k;
  int          m_drop;

  function automatic logic [63:0] pack_q();
    logic [63:0] w = '0;
    foreach (accq[i]) w[16*i +: 16] = accq[i];
    return w;
  endfunction

  always @(posedge clk) begin
    bit can, load, req;
    logic [63:0] ld;
    logic [3:0] lk;
    if (rst) begin
      accq.delete();
      m_idle = 0; m_pend = 0; m_v = 0; m_d = '0; m_k = '0; m_drop = 0;
    end else begin
      can = !m_v || out_ready;
      load = 0; ld = '0; lk = '0;
      if (accq.size() == 4) begin
        if (can) begin
          load = 1; ld = pack_q(); lk = 4'hF;
          accq.delete(); m_pend = 0; m_idle = 0;
          if (pkt_valid) accq.push_back(byte2_pkt);
        end else if (pkt_valid && STATS && m_drop < 16'hFFFF) m_drop++;
      end else if (accq.size() == 0) begin
        if (pkt_valid) accq.push_back(byte2_pkt);
        m_idle = 0; m_pend = 0;
      end else begin
        req = flush || m_pend || (!pkt_valid && m_idle == TO - 1);
        if (pkt_valid) accq.push_back(byte2_pkt);
        if (accq.size() == 4) m_idle = 0;
        else if (req && can) begin
          load = 1; ld = pack_q(); lk = 4'((1 << accq.size()) - 1);
          accq.delete(); m_pend = 0; m_idle = 0;
        end else begin
          m_pend = m_pend || flush;
          if (pkt_valid) m_idle = 0;
          else if (m_idle < TO - 1) m_idle++;
        end
      end
      if (load) begin m_v = 1; m_d = ld; m_k = lk; end
      else if (m_v && out_ready) m_v = 0;
    end
  end

  always @(posedge clk) begin
    #1;
    chk("valid", {63'd0, out_valid}, {63'd0, m_v});
    if (m_v) begin
      chk("data", out_data, m_d);
      chk("keep", {60'd0, out_keep}, {60'd0, m_k});
    end
    chk("drop", {48'd0, drop_cnt}, 64'(m_drop));
  end

  task automatic cyc(input bit v, input logic [15:0] p, input bit f, input bit r);
    pkt_valid = v; byte2_pkt = p; flush = f; out_ready = r;
    @(posedge clk); #2;
  endtask

  initial begin
    logic [63:0] w1;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_data", out_data, 64'd0);
    chk("rst_keep", {60'd0, out_keep}, 64'd0);
    chk("rst_drop", {48'd0, drop_cnt}, 64'd0);
    rst = 1'b0;

    // four back-to-back packets
    cyc(1, 16'h1111, 0, 1); cyc(1, 16'h2222, 0, 1);
    cyc(1, 16'h3333, 0, 1); cyc(1, 16'h4444, 0, 1);
    chk("full_lat0", {63'd0, out_valid}, 64'd0);
    cyc(0, 0, 0, 1);
    chk("full_v", {63'd0, out_valid}, 64'd1);
    chk("full_d", out_data, 64'h4444_3333_2222_1111);
    chk("full_k", {60'd0, out_keep}, 64'hF);
    cyc(0, 0, 0, 1);
    chk("full_once", {63'd0, out_valid}, 64'd0);

    // timeout flush of a partial word
    cyc(1, 16'hAAAA, 0, 1); cyc(1, 16'hBBBB, 0, 1);
    repeat (TO - 1) cyc(0, 0, 0, 1);
    chk("to_early", {63'd0, out_valid}, 64'd0);
    cyc(0, 0, 0, 1);
    chk("to_v", {63'd0, out_valid}, 64'd1);
    chk("to_k", {60'd0, out_keep}, 64'h3);
    chk("to_d", {32'd0, out_data[31:0]}, 64'hBBBB_AAAA);
    chk("to_idle", 64'(dut.state_q), 64'(IDLE));
    cyc(0, 0, 0, 1);

    // packet together with flush
    cyc(1, 16'h5555, 0, 1);
    cyc(1, 16'h1234, 1, 1);
    chk("fl_k", {60'd0, out_keep}, 64'h3);
    chk("fl_d", out_data, 64'h0000_0000_1234_5555);
    cyc(0, 0, 0, 1);

    // reset mid-word
    cyc(1, 16'h0A01, 0, 1); cyc(1, 16'h0A02, 0, 1); cyc(1, 16'h0A03, 0, 1);
    rst = 1'b1;
    cyc(0, 0, 0, 1);
    rst = 1'b0;
    repeat (4) cyc(0, 0, 0, 1);
    chk("rst_novalid", {63'd0, out_valid}, 64'd0);
    cyc(1, 16'hCE10, 0, 1);
    cyc(0, 0, 1, 1);
    chk("rst_lane0_k", {60'd0, out_keep}, 64'h1);
    chk("rst_lane0_d", out_data, 64'h0000_0000_0000_CE10);
    cyc(0, 0, 0, 1);

    // backpressure and drops
    for (int k = 1; k <= 12; k++) begin
      cyc(1, 16'h0100 + 16'(k), 0, 0);
      if (k >= 6) chk("bp_hold", out_data, 64'h0104_0103_0102_0101);
    end
    chk("bp_v", {63'd0, out_valid}, 64'd1);
    chk("bp_drop", {48'd0, drop_cnt}, STATS ? 64'd4 : 64'd0);
    cyc(0, 0, 0, 1);
    chk("bp_w2", out_data, 64'h0108_0107_0106_0105);
    cyc(0, 0, 0, 1);
    chk("bp_empty", {63'd0, out_valid}, 64'd0);

    // randomized traffic
    rst = 1'b1; cyc(0, 0, 0, 1); rst = 1'b0;
    for (int seg = 0; seg < 60; seg++) begin
      int pv_pct = (seg % 2) ? 85 : 8;
      int rd_pct = $urandom_range(20, 100);
      for (int c = 0; c < 64; c++) begin
        w1 = 64'($urandom);
        if ($urandom_range(0, 999) < 3) rst = 1'b1;
        cyc($urandom_range(0, 99) < pv_pct, w1[15:0],
            $urandom_range(0, 99) < 5, $urandom_range(0, 99) < rd_pct);
        rst = 1'b0;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/byte2_pkt_packer.md
BYTE2_PKT_PACKER -- requirements
Module: byte2_pkt_packer

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16: idle cycles in FILL before a partial word is auto-flushed; legal range 2..255.
REQ-002 SHALL have port clk, input, 1: single clock; all logic is clocked on its rising edge.
REQ-003 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-004 SHALL have port byte2_pkt, input, 16: packet from the upstream 2-byte packet finder.
REQ-005 SHALL have port pkt_valid, input, 1: byte2_pkt is valid this cycle. There is no backpressure to the upstream stage.
REQ-006 SHALL have port flush, input, 1: force emission of a partial word.
REQ-007 SHALL have port out_data, output, 64: packed word.
REQ-008 SHALL have port out_keep, output, 4: bit i set means lane i (out_data[16i+15:16i]) holds a valid packet.
REQ-009 SHALL have port out_valid, output, 1: out_data/out_keep are valid.
REQ-010 SHALL have port out_ready, input, 1: downstream accepts the word when out_valid && out_ready.
REQ-011 SHALL have port drop_cnt, output, 16: count of packets dropped.

Function
REQ-012 SHALL keep an accumulator (4 lanes x 16 bits, plus lane count) and one output holding register.
REQ-013 SHALL fill lanes in arrival order, lane 0 first; the first packet of a word goes to out_data[15:0].
REQ-014 SHALL implement an FSM with three states: IDLE (0 lanes), FILL (1-3 lanes) and FULL (4 lanes awaiting the output register).
REQ-015 Transitions SHALL be: IDLE->FILL on an accepted packet; FILL->FULL on the 4th packet; FULL->IDLE on transfer; FILL->IDLE on flush or timeout transfer.
REQ-016 SHALL transfer the accumulator to the output register when the output register is empty or is drained in the same cycle (out_valid && out_ready).
REQ-017 Latency SHALL be: 4th packet accepted at edge N gives out_valid=1 after edge N+1, when the output register is free.
REQ-018 SHALL hold out_valid, out_data and out_keep stable until out_ready is sampled high.
REQ-019 In FULL with the transfer blocked, SHALL drop an arriving valid packet and increment drop_cnt.
REQ-020 The idle counter SHALL increment each FILL cycle without pkt_valid, clear on any accepted packet, and move the partial word at count TIMEOUT-1 with out_keep = lanes filled.
REQ-021 flush SHALL have no effect in IDLE, move the partial word in FILL, and act as a normal full transfer in FULL.
REQ-022 When pkt_valid and flush occur together in FILL, SHALL include the packet in the flushed word.
REQ-023 When the output register is busy, a flush/timeout transfer SHALL wait, with flush remembered as pending; packets arriving meanwhile still fill free lanes.
REQ-024 drop_cnt SHALL saturate at 16'hFFFF.

Reset
REQ-025 On rst SHALL force the FSM to IDLE, lane count 0, idle counter 0, out_valid 0, out_data 64'h0, out_keep 4'h0, drop_cnt 16'h0.
REQ-026 Reset mid-word SHALL discard accumulated packets and the output word without emitting them.
REQ-027 The first packet after rst deasserts SHALL land in lane 0.

Configuration
REQ-028 Macro BYTE2_PKT_PACKER_STATS_EN SHALL control the drop counter.
REQ-029 With BYTE2_PKT_PACKER_STATS_EN defined, drop_cnt SHALL count per REQ-019/REQ-024.
REQ-030 Without BYTE2_PKT_PACKER_STATS_EN, the counter logic SHALL be absent, drop_cnt SHALL be tied to 16'h0, and drops still occur silently.

Structure
REQ-031 Package byte2_pkt_pkg SHALL hold PKT_W=16, LANES=4, WORD_W=64 and the FSM state enum (IDLE, FILL, FULL).
REQ-032 The output holding register with valid/ready handling SHALL be a sub-module named byte2_pkt_out_reg.

Verification
REQ-033 Send 4 consecutive packets 1111, 2222, 3333, 4444 with out_ready=1 -> one cycle later out_data=64'h4444_3333_2222_1111, out_keep=4'hF, out_valid for exactly 1 cycle.
REQ-034 Send 2 packets (AAAA, BBBB) then idle for TIMEOUT=16 cycles -> out_keep=4'h3, out_data[31:0]=32'hBBBB_AAAA, FSM returns to IDLE.
REQ-035 Hold out_ready=0 and send 12 packets -> first word held stable, second word sits in FULL, last 4 dropped, drop_cnt=4 (with macro defined) or 0 (without).
REQ-036 Send pkt 0x1234 together with flush while in FILL with 1 lane -> out_keep=4'h3, with the packet in lane 1.
REQ-037 Assert rst after 3 packets -> out_valid stays 0 and no word is emitted; a new packet 0xCE10 lands in lane 0 of the next word.
